add_sub_pipe: RTL and testbench
===============================

Name: add_sub_pipe

Overview:
- Parametrised, pipelined adder/subtractor for the Stage 2 datapath; the next generation of the 16-bit combinational add/sub.
- Splits the operand width into STAGES equal chunks and registers the carry between chunks, so timing holds at wider WIDTH.
- Adds signed saturation, N/Z/V flags and a valid/ready handshake with backpressure.
- Feeds the ALU result mux and the PC/address adders.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline stages, equal to the latency; CHUNK = WIDTH/STAGES bits are added per stage.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- In_valid  in  1  input operands valid.
- In_ready  out  1  block can accept a new operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Sub  in  1  1 = A-B, 0 = A+B.
- Sat  in  1  1 = clamp signed overflow.
- Out_valid  out  1  result valid.
- Out_ready  in  1  consumer accepts the result.
- Sum  out  WIDTH  result, post-saturation.
- Cout  out  1  raw carry out of the MSB; for subtract, 1 = no borrow.
- V  out  1  raw signed overflow, before saturation.
- N  out  1  MSB of Sum.
- Z  out  1  Sum == 0.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all stage valid bits, Out_valid, Sum, Cout, V, N and Z are 0. In_ready is 1 once rst deasserts.
- Reset mid-operation: all in-flight operations are discarded and no partial result is presented.
- Subtract: computed as A + ~B + 1, with the carry-in of chunk 0 equal to Sub.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and B(^Sub) with the registered carry from stage k-1.
  - Chunks not yet summed travel alongside in stage registers.
  - Sum bits already produced are registered forward.
- Final stage:
  - Cout = carry out of the top chunk.
  - V = (a_msb == b'_msb) && (raw_msb != a_msb), where b' is B after the Sub inversion.
  - If Sat && V: Sum = 0 followed by WIDTH-1 ones if a_msb == 0 (positive overflow), else 1 followed by WIDTH-1 zeros. Otherwise Sum = raw result.
  - N and Z are derived from the post-saturation Sum.
- Latency: STAGES cycles from an accepted input (In_valid && In_ready at an edge) to Out_valid. Throughput is 1 operation per cycle.
- Handshake:
  - stall = Out_valid && !Out_ready.
  - In_ready = !stall.
  - While stalled, all stage registers and outputs hold, including bubbles.
  - When not stalled, the pipeline advances, and a bubble (In_valid = 0) enters as an invalid slot.
  - Results leave in issue order; none are dropped or duplicated.
  - Outputs remain stable while Out_valid && !Out_ready.
- Simultaneous events: output acceptance and new input in the same cycle are both taken, with no bubble inserted.
- Wrap-around: without Sat, results are modulo 2^WIDTH; Cout and V still report.
- Operands are sampled only on acceptance; changes to A, B, Sub or Sat while In_ready = 0 are ignored.

Decomposition:
- Shared include add_sub_defs:
  - localparam CHUNK = WIDTH/STAGES.
  - SAT_POS/SAT_NEG constant builders.
  - Elaboration-time check that WIDTH % STAGES == 0.
- Sub-module add_sub_chunk: combinational CHUNK-bit ripple adder with inputs a, b, cin and outputs s, cout. It is instantiated once per stage in a generate loop.
- Pipeline registers, the stall/valid chain and the saturation/flag logic stay in add_sub_pipe.

Test Plan (WIDTH=16, STAGES=2, Out_ready=1 unless noted):
1. Hold rst=1, then pulse rst low-to-high mid-stream with two operations in flight → Out_valid=0 and Sum=0 immediately and asynchronously. After release, no stale results appear and In_ready=1.
2. Add 0x00FF+0x0001 (carry crosses the chunk boundary) → after 2 cycles Sum=0x0100, Cout=0, V=0, Z=0. Then add 0xFFFF+0x0001 → Sum=0x0000, Cout=1, Z=1.
3. Subtract 0x0005-0x0007 → Sum=0xFFFE, Cout=0, N=1, V=0. Subtract 0x0007-0x0005 → Sum=0x0002, Cout=1.
4. Saturation:
   - 0x7FFF+0x0001 with Sat=0 → Sum=0x8000, V=1, N=1.
   - Same with Sat=1 → Sum=0x7FFF, V=1, N=0.
   - 0x8000-0x0001 with Sat=1 → Sum=0x8000, V=1.
5. Backpressure: issue 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) and hold Out_ready=0 for 3 cycles once Out_valid rises → In_ready=0 during the stall and Sum stays stable. Results 2, 4, 6, 8 appear in order, each exactly once.
6. Random soak: 16384 random add/sub/sat operations with random In_valid and Out_ready → every result matches a scoreboard reference for Sum, Cout, V, N and Z, in order.

Source files
------------

// File: rtl/add_sub_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: chunk sizing,
// saturation constant builders and parameter legality check.
package add_sub_pipe_pkg;

   localparam int unsigned MAX_WIDTH = 256;

   function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
      return width / stages;
   endfunction

   function automatic bit width_ok(input int unsigned width, input int unsigned stages);
      return (stages != 0) && (width >= stages) && (width <= MAX_WIDTH) && ((width % stages) == 0);
   endfunction

   // Largest positive signed value of the given width (0 then all ones).
   function automatic logic [MAX_WIDTH-1:0] sat_pos(input int unsigned width);
      return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
   endfunction

   // Most negative signed value of the given width (1 then all zeros).
   function automatic logic [MAX_WIDTH-1:0] sat_neg(input int unsigned width);
      return MAX_WIDTH'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; one instance per pipeline stage.
module add_sub_chunk
   import add_sub_pipe_pkg::*;
#(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic c;

   always_comb begin
      s = '0;
      c = cin;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined signed/unsigned adder-subtractor: one CHUNK-bit slice per stage,
// carry registered between slices, saturation and N/Z/V flags at the output.
module add_sub_pipe
   import add_sub_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   input  logic             Sat,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             V,
   output logic             N,
   output logic             Z
);

   localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
   localparam int unsigned LAST  = STAGES - 1;
   localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));

   if (!width_ok(WIDTH, STAGES)) begin : g_param_check
      $error("add_sub_pipe: WIDTH must be a nonzero multiple of STAGES");
   end

   logic stall;

   assign stall    = Out_valid && !Out_ready;
   assign In_ready = !stall;

   // Stage k sees only the operand bits from chunk k upward plus the sum bits
   // already produced, so every register is exactly as wide as it needs to be.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned LO = k * CHUNK;
      localparam int unsigned UW = WIDTH - LO;

      logic              v_i;
      logic              sat_i;
      logic              c_i;
      logic [UW-1:0]     a_i;
      logic [UW-1:0]     bx_i;
      logic [CHUNK-1:0]  sum_c;
      logic              cout_c;
      logic [LO+CHUNK-1:0] s_n;

      if (k == 0) begin : g_first
         assign v_i   = In_valid;
         assign sat_i = Sat;
         assign c_i   = Sub;
         assign a_i   = A;
         assign bx_i  = B ^ {WIDTH{Sub}};
         assign s_n   = sum_c;
      end else begin : g_next
         assign v_i   = g_stage[k-1].g_reg.v_q;
         assign sat_i = g_stage[k-1].g_reg.sat_q;
         assign c_i   = g_stage[k-1].g_reg.c_q;
         assign a_i   = g_stage[k-1].g_reg.a_q;
         assign bx_i  = g_stage[k-1].g_reg.bx_q;
         assign s_n   = {sum_c, g_stage[k-1].g_reg.s_q};
      end

      add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a    (a_i[CHUNK-1:0]),
         .b    (bx_i[CHUNK-1:0]),
         .cin  (c_i),
         .s    (sum_c),
         .cout (cout_c)
      );

      if (k < LAST) begin : g_reg
         localparam int unsigned RW = UW - CHUNK;

         logic                v_q;
         logic                sat_q;
         logic                c_q;
         logic [RW-1:0]       a_q;
         logic [RW-1:0]       bx_q;
         logic [LO+CHUNK-1:0] s_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               {v_q, sat_q, c_q, a_q, bx_q, s_q} <= '0;
            end else if (!stall) begin
               v_q   <= v_i;
               sat_q <= sat_i;
               c_q   <= cout_c;
               a_q   <= a_i[UW-1:CHUNK];
               bx_q  <= bx_i[UW-1:CHUNK];
               s_q   <= s_n;
            end
         end
      end
   end

   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] res;
   logic             a_msb;
   logic             b_msb;
   logic             ovf;

   assign raw   = g_stage[LAST].s_n;
   assign a_msb = g_stage[LAST].a_i[CHUNK-1];
   assign b_msb = g_stage[LAST].bx_i[CHUNK-1];

   always_comb begin
      ovf = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
      res = raw;
      if (g_stage[LAST].sat_i && ovf) begin
         res = a_msb ? SAT_NEG : SAT_POS;
      end
   end

   // Result fields only load on a valid slot, so Sum keeps the last result
   // while bubbles pass through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {Out_valid, Sum, Cout, V, N, Z} <= '0;
      end else if (!stall) begin
         Out_valid <= g_stage[LAST].v_i;
         if (g_stage[LAST].v_i) begin
            Sum  <= res;
            Cout <= g_stage[LAST].cout_c;
            V    <= ovf;
            N    <= res[WIDTH-1];
            Z    <= (res == '0);
         end
      end
   end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (WIDTH=16, STAGES=2): directed vectors,
// reset, backpressure and a randomized soak against an arithmetic reference.
module tb_add_sub_pipe;

   localparam int W  = 16;
   localparam int ST = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         In_valid = 1'b0;
   logic         In_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Sub = 1'b0;
   logic         Sat = 1'b0;
   logic         Out_valid;
   logic         Out_ready = 1'b1;
   logic [W-1:0] Sum;
   logic         Cout, V, N, Z;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_acc  = 0;

   typedef struct {
      logic [15:0] sum;
      logic        cout, v, n, z;
      int          cyc;
   } res_t;

   typedef struct {
      logic [15:0] a, b;
      logic        sub, sat;
      logic [15:0] sum;
      logic        cout, v, n, z;
   } vec_t;

   res_t exp_q[$];
   res_t obs_q[$];

   always #5 clk = ~clk;

   add_sub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
      .clk       (clk),
      .rst       (rst),
      .In_valid  (In_valid),
      .In_ready  (In_ready),
      .A         (A),
      .B         (B),
      .Sub       (Sub),
      .Sat       (Sat),
      .Out_valid (Out_valid),
      .Out_ready (Out_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .V         (V),
      .N         (N),
      .Z         (Z)
   );

   // Reference: exact signed arithmetic, then range check and clamp.
   function automatic res_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                      input logic sub, input logic sat);
      res_t r;
      int sa, sb, exact;
      int unsigned ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      exact  = sub ? sa - sb : sa + sb;
      r.cout = sub ? (ua >= ub) : ((ua + ub) > 65535);
      r.v    = (exact > 32767) || (exact < -32768);
      if (sat && r.v) r.sum = (exact > 0) ? 16'h7FFF : 16'h8000;
      else            r.sum = 16'(exact);
      r.n   = r.sum[15];
      r.z   = (r.sum == 16'h0000);
      r.cyc = 0;
      return r;
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h7FFF;
         2:       return 16'h8000;
         3:       return 16'hFFFF;
         4:       return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   // One clock: record accepted operations and consumed results, then advance.
   task automatic step();
      res_t r;
      #1;
      if (In_valid && In_ready) begin
         r = ref_model(A, B, Sub, Sat);
         r.cyc = cyc;
         exp_q.push_back(r);
         n_acc++;
      end
      if (Out_valid && Out_ready) begin
         r.sum = Sum; r.cout = Cout; r.v = V; r.n = N; r.z = Z;
         r.cyc = cyc;
         obs_q.push_back(r);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      In_valid = 1'b0;
      Out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({Out_valid, Sum, Cout, V, N, Z} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%b sum=%h c=%b v=%b n=%b z=%b want all 0",
                  Out_valid, Sum, Cout, V, N, Z);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (In_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", In_ready);
      end
      step();
      A = 16'h1234; B = 16'h1111; Sub = 1'b0; Sat = 1'b0; In_valid = 1'b1;
      step();
      A = 16'h0101; B = 16'h0101;
      step();
      In_valid = 1'b0;
      #2;
      checks++;
      if (Out_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_inflight_valid got %b want 1", Out_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (Out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_valid got %b want 0", Out_valid);
      end
      checks++;
      if (Sum !== 16'h0000) begin
         errors++;
         $display("FAIL reset_async_sum got %h want 0000", Sum);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      obs_q.delete();
      repeat (6) step();
      checks++;
      if (obs_q.size() != 0 || Out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_stale got %0d results valid=%b want 0 results valid=0",
                  obs_q.size(), Out_valid);
      end
      checks++;
      if (In_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_after got %b want 1", In_ready);
      end
   endtask

   task automatic test_directed();
      vec_t vecs[9] = '{
         '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0},
         '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1},
         '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0},
         '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0},
         '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0},
         '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0},
         '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0},
         '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0},
         '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1}
      };
      res_t o;
      Out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         exp_q.delete();
         obs_q.delete();
         A = vecs[i].a; B = vecs[i].b; Sub = vecs[i].sub; Sat = vecs[i].sat;
         In_valid = 1'b1;
         step();
         In_valid = 1'b0;
         for (int t = 0; t < 8 && obs_q.size() == 0; t++) step();
         checks++;
         if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL dir%0d_count got %0d results %0d accepted want 1 and 1",
                     i, obs_q.size(), exp_q.size());
         end else begin
            o = obs_q[0];
            if ({o.sum, o.cout, o.v, o.n, o.z} !==
                {vecs[i].sum, vecs[i].cout, vecs[i].v, vecs[i].n, vecs[i].z}) begin
               errors++;
               $display("FAIL dir%0d_result got sum=%h c=%b v=%b n=%b z=%b want sum=%h c=%b v=%b n=%b z=%b",
                        i, o.sum, o.cout, o.v, o.n, o.z,
                        vecs[i].sum, vecs[i].cout, vecs[i].v, vecs[i].n, vecs[i].z);
            end
            checks++;
            if (o.cyc - exp_q[0].cyc != ST) begin
               errors++;
               $display("FAIL dir%0d_latency got %0d want %0d", i, o.cyc - exp_q[0].cyc, ST);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_q.delete();
      obs_q.delete();
      Out_ready = 1'b1; Sub = 1'b0; Sat = 1'b0;
      A = 16'd1; B = 16'd1; In_valid = 1'b1;
      step();
      A = 16'd2; B = 16'd2;
      step();
      checks++;
      if (Out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_valid_rise got %b want 1", Out_valid);
      end
      // Junk operands while stalled must never be accepted.
      Out_ready = 1'b0;
      A = 16'hDEAD; B = 16'hBEEF; Sub = 1'b1; Sat = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (In_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready cycle %0d got %b want 0", i, In_ready);
         end
         checks++;
         if (Out_valid !== 1'b1 || Sum !== 16'd2) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got valid=%b sum=%h want valid=1 sum=0002",
                     i, Out_valid, Sum);
         end
         step();
      end
      Out_ready = 1'b1;
      A = 16'd3; B = 16'd3; Sub = 1'b0; Sat = 1'b0;
      step();
      A = 16'd4; B = 16'd4;
      step();
      In_valid = 1'b0;
      for (int t = 0; t < 20 && obs_q.size() < 4; t++) step();
      repeat (4) step();
      checks++;
      if (obs_q.size() != 4) begin
         errors++;
         $display("FAIL bp_count got %0d results want 4", obs_q.size());
      end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i].sum !== 16'(2 * (i + 1))) begin
            errors++;
            $display("FAIL bp_order%0d got %h want %h", i, obs_q[i].sum, 16'(2 * (i + 1)));
         end
      end
   endtask

   task automatic test_random();
      res_t o, e;
      int start, budget, shown;
      exp_q.delete();
      obs_q.delete();
      start = n_acc;
      budget = 0;
      shown = 0;
      while ((n_acc - start) < 16384 && budget < 80000) begin
         In_valid  = ($urandom_range(0, 3) != 0);
         Out_ready = ($urandom_range(0, 3) != 0);
         A = pick(); B = pick();
         Sub = 1'($urandom_range(0, 1));
         Sat = 1'($urandom_range(0, 1));
         step();
         budget++;
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rnd_extra got sum=%h want no result", o.sum);
            end else begin
               e = exp_q.pop_front();
               if ({o.sum, o.cout, o.v, o.n, o.z} !== {e.sum, e.cout, e.v, e.n, e.z}) begin
                  errors++;
                  if (shown < 10) begin
                     shown++;
                     $display("FAIL rnd_result got sum=%h c=%b v=%b n=%b z=%b want sum=%h c=%b v=%b n=%b z=%b",
                              o.sum, o.cout, o.v, o.n, o.z, e.sum, e.cout, e.v, e.n, e.z);
                  end
               end
            end
         end
      end
      checks++;
      if ((n_acc - start) < 16384) begin
         errors++;
         $display("FAIL rnd_budget got %0d accepted want 16384", n_acc - start);
      end
      In_valid = 1'b0;
      Out_ready = 1'b1;
      for (int t = 0; t < 50 && exp_q.size() > 0; t++) begin
         step();
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if ({o.sum, o.cout, o.v, o.n, o.z} !== {e.sum, e.cout, e.v, e.n, e.z}) begin
               errors++;
               $display("FAIL rnd_drain got sum=%h c=%b v=%b n=%b z=%b want sum=%h c=%b v=%b n=%b z=%b",
                        o.sum, o.cout, o.v, o.n, o.z, e.sum, e.cout, e.v, e.n, e.z);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL rnd_leftover got %0d missing %0d extra want 0 and 0",
                  exp_q.size(), obs_q.size());
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
